id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised decode stage: a register file with a dedicated write-back port, internal write-through bypass and an optional hardwired zero register, plus the ID/EX pipeline register. It resolves source operands through external forwarding selects and sign/zero-extends the immediate. It supports hold, bubble and flush control for hazard and branch handling. It sits between the IF/ID register and the execute stage of the 5-stage pipeline.

## Interface
- WIDTH, 32, datapath and register width
- REGS, 32, number of architectural registers (power of two); AW = log2(REGS)
- IMM_W, 16, raw immediate width (IMM_W < WIDTH)
- CTRL_W, 10, width of packed control bundle passed to EX
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- Id_Valid  in  1  ID holds a real instruction
- AddrRs, AddrRt, AddrRd  in  AW each  source/destination register addresses
- Imm  in  IMM_W  raw immediate; ImmZext  in  1  1 = zero-extend, 0 = sign-extend
- PC  in  WIDTH  PC+4 of the instruction in ID
- Ctrl  in  CTRL_W  control bundle from the main decoder
- Fwd_Rs, Fwd_Rt  in  2 each  operand select: 00 register file, 01 MemWbFwdData, 10 ExMemFwdData, 11 treated as 00
- MemWbFwdData, ExMemFwdData  in  WIDTH  forwarded results
- Wb_RegWrite  in  1; Wb_Addr  in  AW; Wb_Data  in  WIDTH  write-back port
- Hold  in  1  EX stalled; ID/EX keeps its contents
- Bubble  in  1  insert a NOP into ID/EX (load-use stall)
- Flush  in  1  kill the instruction entering ID/EX (taken branch/jump)
- BranchTarget  out  WIDTH  combinational PC + (sext(Imm) << 2)
- IdEx_Valid  out  1; IdEx_Ctrl  out  CTRL_W
- IdEx_DataRs, IdEx_DataRt, IdEx_Imm, IdEx_PC  out  WIDTH each
- IdEx_AddrRs, IdEx_AddrRt, IdEx_AddrRd  out  AW each

## Operation
- Register file: REGS x WIDTH. Write at the clock edge when Wb_RegWrite=1 and not RST, unless ZERO_REG=1 and Wb_Addr=0. Hold, Bubble and Flush never block writes.
- Read: combinational. With ZERO_REG=1, address 0 returns 0. If Wb_RegWrite=1, Wb_Addr equals the read address, and that address is not the suppressed zero register, the read returns Wb_Data (write-through bypass).
- Operand = mux(Fwd_x) over {bypassed read, MemWbFwdData, ExMemFwdData}; 11 selects the read.
- Immediate: ImmZext ? zero-extend : sign-extend Imm to WIDTH. BranchTarget always uses the sign-extended value, shifted left 2, added modulo 2^WIDTH.
- ID/EX update priority per edge:
  - RST: all ID/EX outputs 0 and all registers 0.
  - Flush: IdEx_Valid=0, IdEx_Ctrl=0; data/address fields load normally (don't-care).
  - Hold: every ID/EX field keeps its value.
  - Bubble: same as Flush.
  - Otherwise: IdEx_Valid=Id_Valid, and IdEx_Ctrl=Id_Valid ? Ctrl : 0. All other fields load.
- Flush overrides Hold: a killed instruction must not remain in EX.

## Timing
- Latency: ID inputs appear on IdEx_* one cycle after the edge at which they are sampled.
- Reset: every output register reads 0 after the first RST edge and stays 0 while RST=1. BranchTarget follows PC/Imm combinationally even during reset.
- Reset mid-operation: an in-flight instruction is discarded. A simultaneous Wb write is dropped.
- Write and read of the same register in the same cycle: the new value is forwarded (bypass). The array is updated at the same edge.
- Write to register 0 with ZERO_REG=1: no effect, and no bypass.
- Hold asserted for N cycles: outputs remain constant for N cycles. Register-file writes continue, but a held ID/EX entry is not refreshed.

## Test plan
- Reset, then read all addresses -> IdEx_DataRs=0 for every address; IdEx_Valid=0; IdEx_Ctrl=0.
- Write r5=0xDEADBEEF; next cycle AddrRs=5, Fwd_Rs=00 -> one cycle later IdEx_DataRs=0xDEADBEEF. Write r0=0x1234 with ZERO_REG=1 -> reading r0 gives 0.
- Same cycle Wb_Addr=7, Wb_Data=0xA5A5A5A5 with AddrRt=7 -> IdEx_DataRt=0xA5A5A5A5 on the next edge (bypass).
- Fwd_Rs=10, ExMemFwdData=0x11, Fwd_Rt=01, MemWbFwdData=0x22 -> IdEx_DataRs=0x11, IdEx_DataRt=0x22.
- Imm=0xFFFC, PC=0x100, ImmZext=0 -> IdEx_Imm=0xFFFFFFFC, BranchTarget=0xF0. With ImmZext=1 -> IdEx_Imm=0x0000FFFC.
- Load ID/EX with Ctrl=0x3FF; assert Hold 3 cycles -> Ctrl stays 0x3FF. Assert Hold+Flush together -> IdEx_Valid=0, Ctrl=0. Bubble alone -> IdEx_Valid=0, Ctrl=0. RST mid-Hold -> all outputs 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode stage: register file with bypass, operand forwarding, immediate extension and ID/EX register
module id_ex_stage #(
   parameter int WIDTH    = 32,
   parameter int REGS     = 32,
   parameter int IMM_W    = 16,
   parameter int CTRL_W   = 10,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(REGS)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Id_Valid,
   input  logic [AW-1:0]     AddrRs,
   input  logic [AW-1:0]     AddrRt,
   input  logic [AW-1:0]     AddrRd,
   input  logic [IMM_W-1:0]  Imm,
   input  logic              ImmZext,
   input  logic [WIDTH-1:0]  PC,
   input  logic [CTRL_W-1:0] Ctrl,
   input  logic [1:0]        Fwd_Rs,
   input  logic [1:0]        Fwd_Rt,
   input  logic [WIDTH-1:0]  MemWbFwdData,
   input  logic [WIDTH-1:0]  ExMemFwdData,
   input  logic              Wb_RegWrite,
   input  logic [AW-1:0]     Wb_Addr,
   input  logic [WIDTH-1:0]  Wb_Data,
   input  logic              Hold,
   input  logic              Bubble,
   input  logic              Flush,
   output logic [WIDTH-1:0]  BranchTarget,
   output logic              IdEx_Valid,
   output logic [CTRL_W-1:0] IdEx_Ctrl,
   output logic [WIDTH-1:0]  IdEx_DataRs,
   output logic [WIDTH-1:0]  IdEx_DataRt,
   output logic [WIDTH-1:0]  IdEx_Imm,
   output logic [WIDTH-1:0]  IdEx_PC,
   output logic [AW-1:0]     IdEx_AddrRs,
   output logic [AW-1:0]     IdEx_AddrRt,
   output logic [AW-1:0]     IdEx_AddrRd
);

   logic [WIDTH-1:0]  rf_q [REGS];

   logic              wr_en;
   logic [WIDTH-1:0]  rd_rs, rd_rt;
   logic [WIDTH-1:0]  op_rs, op_rt;
   logic [WIDTH-1:0]  imm_sext, imm_ext;

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [WIDTH-1:0]  rs_q, rs_d, rt_q, rt_d, imm_q, imm_d, pc_q, pc_d;
   logic [AW-1:0]     ars_q, ars_d, art_q, art_d, ard_q, ard_d;

   // Writes to the hardwired zero register are suppressed, including their bypass
   assign wr_en = Wb_RegWrite && !((ZERO_REG != 0) && (Wb_Addr == '0));

   // Register file array; reset clears every entry and drops a concurrent write
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
      end else if (wr_en) begin
         rf_q[Wb_Addr] <= Wb_Data;
      end
   end

   // Combinational reads with zero register and write-through bypass
   always_comb begin
      rd_rs = rf_q[AddrRs];
      rd_rt = rf_q[AddrRt];
      if (wr_en && (Wb_Addr == AddrRs)) rd_rs = Wb_Data;
      if (wr_en && (Wb_Addr == AddrRt)) rd_rt = Wb_Data;
      if ((ZERO_REG != 0) && (AddrRs == '0)) rd_rs = '0;
      if ((ZERO_REG != 0) && (AddrRt == '0)) rd_rt = '0;
   end

   // External forwarding selects; code 11 falls back to the register file
   always_comb begin
      case (Fwd_Rs)
         2'b01:   op_rs = MemWbFwdData;
         2'b10:   op_rs = ExMemFwdData;
         default: op_rs = rd_rs;
      endcase
      case (Fwd_Rt)
         2'b01:   op_rt = MemWbFwdData;
         2'b10:   op_rt = ExMemFwdData;
         default: op_rt = rd_rt;
      endcase
   end

   // Immediate extension; branch target always uses the signed form
   assign imm_sext     = {{(WIDTH-IMM_W){Imm[IMM_W-1]}}, Imm};
   assign imm_ext      = ImmZext ? {{(WIDTH-IMM_W){1'b0}}, Imm} : imm_sext;
   assign BranchTarget = PC + (imm_sext << 2);

   // ID/EX next state: Flush beats Hold, Hold beats Bubble
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      imm_d   = imm_q;
      pc_d    = pc_q;
      ars_d   = ars_q;
      art_d   = art_q;
      ard_d   = ard_q;
      if (Flush || !Hold) begin
         rs_d  = op_rs;
         rt_d  = op_rt;
         imm_d = imm_ext;
         pc_d  = PC;
         ars_d = AddrRs;
         art_d = AddrRt;
         ard_d = AddrRd;
         if (Flush || Bubble) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end else begin
            valid_d = Id_Valid;
            ctrl_d  = Id_Valid ? Ctrl : '0;
         end
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         ars_q   <= '0;
         art_q   <= '0;
         ard_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
         ars_q   <= ars_d;
         art_q   <= art_d;
         ard_q   <= ard_d;
      end
   end

   assign IdEx_Valid  = valid_q;
   assign IdEx_Ctrl   = ctrl_q;
   assign IdEx_DataRs = rs_q;
   assign IdEx_DataRt = rt_q;
   assign IdEx_Imm    = imm_q;
   assign IdEx_PC     = pc_q;
   assign IdEx_AddrRs = ars_q;
   assign IdEx_AddrRt = art_q;
   assign IdEx_AddrRd = ard_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

   localparam int F_VALID = 0, F_CTRL = 1, F_RS = 2, F_RT = 3, F_IMM = 4, F_PC = 5, F_ARD = 6;

   typedef struct {
      string       tag;
      int          field;
      logic [31:0] val;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST, Id_Valid, ImmZext, Wb_RegWrite, Hold, Bubble, Flush;
   logic [4:0]  AddrRs, AddrRt, AddrRd, Wb_Addr;
   logic [15:0] Imm;
   logic [31:0] PC, MemWbFwdData, ExMemFwdData, Wb_Data;
   logic [9:0]  Ctrl;
   logic [1:0]  Fwd_Rs, Fwd_Rt;
   logic [31:0] BranchTarget, IdEx_DataRs, IdEx_DataRt, IdEx_Imm, IdEx_PC;
   logic        IdEx_Valid;
   logic [9:0]  IdEx_Ctrl;
   logic [4:0]  IdEx_AddrRs, IdEx_AddrRt, IdEx_AddrRd;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   id_ex_stage dut (
      .CLK(CLK), .RST(RST), .Id_Valid(Id_Valid),
      .AddrRs(AddrRs), .AddrRt(AddrRt), .AddrRd(AddrRd),
      .Imm(Imm), .ImmZext(ImmZext), .PC(PC), .Ctrl(Ctrl),
      .Fwd_Rs(Fwd_Rs), .Fwd_Rt(Fwd_Rt),
      .MemWbFwdData(MemWbFwdData), .ExMemFwdData(ExMemFwdData),
      .Wb_RegWrite(Wb_RegWrite), .Wb_Addr(Wb_Addr), .Wb_Data(Wb_Data),
      .Hold(Hold), .Bubble(Bubble), .Flush(Flush),
      .BranchTarget(BranchTarget), .IdEx_Valid(IdEx_Valid), .IdEx_Ctrl(IdEx_Ctrl),
      .IdEx_DataRs(IdEx_DataRs), .IdEx_DataRt(IdEx_DataRt),
      .IdEx_Imm(IdEx_Imm), .IdEx_PC(IdEx_PC),
      .IdEx_AddrRs(IdEx_AddrRs), .IdEx_AddrRt(IdEx_AddrRt), .IdEx_AddrRd(IdEx_AddrRd)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] observe(input int field);
      case (field)
         F_VALID: return {31'b0, IdEx_Valid};
         F_CTRL:  return {22'b0, IdEx_Ctrl};
         F_RS:    return IdEx_DataRs;
         F_RT:    return IdEx_DataRt;
         F_IMM:   return IdEx_Imm;
         F_PC:    return IdEx_PC;
         default: return {27'b0, IdEx_AddrRd};
      endcase
   endfunction

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int field, input logic [31:0] val);
      exp_t e;
      e.tag = tag; e.field = field; e.val = val;
      q.push_back(e);
   endtask

   // one clock edge, then drain the scoreboard against the registered outputs
   task automatic step();
      exp_t e;
      @(posedge CLK);
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         compare(e.tag, observe(e.field), e.val);
      end
   endtask

   initial begin
      RST = 1'b1; Id_Valid = 1'b1; ImmZext = 1'b0; Wb_RegWrite = 1'b0;
      Hold = 1'b0; Bubble = 1'b0; Flush = 1'b0;
      AddrRs = '0; AddrRt = '0; AddrRd = 5'd3; Wb_Addr = '0;
      Imm = 16'h0004; PC = 32'h40; MemWbFwdData = '0; ExMemFwdData = '0; Wb_Data = '0;
      Ctrl = 10'h2AA; Fwd_Rs = 2'b00; Fwd_Rt = 2'b00;

      // reset state
      expect_out("rst_valid", F_VALID, 0);
      expect_out("rst_ctrl", F_CTRL, 0);
      expect_out("rst_pc", F_PC, 0);
      expect_out("rst_ard", F_ARD, 0);
      step();
      #1 compare("rst_btarget", BranchTarget, 32'h50);

      // all registers read zero after reset
      RST = 1'b0; Id_Valid = 1'b0;
      for (int a = 0; a < 32; a++) begin
         AddrRs = a[4:0];
         expect_out($sformatf("rd0_r%0d", a), F_RS, 0);
         expect_out("rd0_valid", F_VALID, 0);
         step();
      end

      // write r5 then read it
      Wb_RegWrite = 1'b1; Wb_Addr = 5'd5; Wb_Data = 32'hDEADBEEF; AddrRs = 5'd0;
      step();
      Wb_RegWrite = 1'b0; AddrRs = 5'd5;
      expect_out("r5_read", F_RS, 32'hDEADBEEF);
      step();

      // zero register ignores writes and bypass
      Wb_RegWrite = 1'b1; Wb_Addr = 5'd0; Wb_Data = 32'h1234; AddrRs = 5'd0;
      expect_out("r0_nobypass", F_RS, 0);
      step();
      Wb_RegWrite = 1'b0;
      expect_out("r0_read", F_RS, 0);
      step();

      // write-through bypass, then array holds the value
      Wb_RegWrite = 1'b1; Wb_Addr = 5'd7; Wb_Data = 32'hA5A5A5A5; AddrRt = 5'd7;
      expect_out("r7_bypass", F_RT, 32'hA5A5A5A5);
      step();
      Wb_RegWrite = 1'b0;
      expect_out("r7_array", F_RT, 32'hA5A5A5A5);
      step();

      // forwarding selects
      Fwd_Rs = 2'b10; ExMemFwdData = 32'h11; Fwd_Rt = 2'b01; MemWbFwdData = 32'h22;
      expect_out("fwd_exmem", F_RS, 32'h11);
      expect_out("fwd_memwb", F_RT, 32'h22);
      step();
      Fwd_Rs = 2'b11; Fwd_Rt = 2'b11; AddrRs = 5'd5;
      expect_out("fwd11_rs", F_RS, 32'hDEADBEEF);
      expect_out("fwd11_rt", F_RT, 32'hA5A5A5A5);
      step();
      Fwd_Rs = 2'b00; Fwd_Rt = 2'b00;

      // immediate extension and branch target
      Imm = 16'hFFFC; PC = 32'h100; ImmZext = 1'b0;
      #1 compare("btarget_neg", BranchTarget, 32'hF0);
      expect_out("imm_sext", F_IMM, 32'hFFFFFFFC);
      expect_out("pc_load", F_PC, 32'h100);
      step();
      ImmZext = 1'b1;
      #1 compare("btarget_zext", BranchTarget, 32'hF0);
      expect_out("imm_zext", F_IMM, 32'h0000FFFC);
      step();

      // load, then hold three cycles while a write lands
      Id_Valid = 1'b1; Ctrl = 10'h3FF; AddrRs = 5'd5; PC = 32'h200;
      expect_out("load_valid", F_VALID, 1);
      expect_out("load_ctrl", F_CTRL, 32'h3FF);
      step();
      Hold = 1'b1; Id_Valid = 1'b0; Ctrl = 10'h155; AddrRs = 5'd7; PC = 32'h300;
      Wb_RegWrite = 1'b1; Wb_Addr = 5'd9; Wb_Data = 32'h99;
      for (int i = 0; i < 3; i++) begin
         expect_out("hold_ctrl", F_CTRL, 32'h3FF);
         expect_out("hold_valid", F_VALID, 1);
         expect_out("hold_rs", F_RS, 32'hDEADBEEF);
         expect_out("hold_pc", F_PC, 32'h200);
         step();
      end
      Wb_RegWrite = 1'b0;

      // flush overrides hold
      Flush = 1'b1;
      expect_out("flush_valid", F_VALID, 0);
      expect_out("flush_ctrl", F_CTRL, 0);
      step();
      Flush = 1'b0; Hold = 1'b0;

      // bubble alone, then bubble under hold
      Id_Valid = 1'b1; Ctrl = 10'h3FF;
      expect_out("reload_ctrl", F_CTRL, 32'h3FF);
      step();
      Bubble = 1'b1;
      expect_out("bubble_valid", F_VALID, 0);
      expect_out("bubble_ctrl", F_CTRL, 0);
      step();
      Bubble = 1'b0; Ctrl = 10'h0F0;
      expect_out("reload2_ctrl", F_CTRL, 32'h0F0);
      step();
      Hold = 1'b1; Bubble = 1'b1;
      expect_out("hold_bubble_ctrl", F_CTRL, 32'h0F0);
      expect_out("hold_bubble_valid", F_VALID, 1);
      step();
      Hold = 1'b0; Bubble = 1'b0;

      // invalid instruction squashes control; write during hold persisted
      Id_Valid = 1'b0; Ctrl = 10'h3FF; AddrRs = 5'd9;
      expect_out("inv_ctrl", F_CTRL, 0);
      expect_out("inv_valid", F_VALID, 0);
      expect_out("r9_held_write", F_RS, 32'h99);
      step();

      // reset mid-hold with a concurrent write
      Id_Valid = 1'b1; Ctrl = 10'h3FF;
      step();
      Hold = 1'b1; RST = 1'b1;
      Wb_RegWrite = 1'b1; Wb_Addr = 5'd10; Wb_Data = 32'hAA;
      expect_out("rst_hold_valid", F_VALID, 0);
      expect_out("rst_hold_ctrl", F_CTRL, 0);
      expect_out("rst_hold_rs", F_RS, 0);
      expect_out("rst_hold_imm", F_IMM, 0);
      step();
      RST = 1'b0; Hold = 1'b0; Wb_RegWrite = 1'b0;
      AddrRs = 5'd5; AddrRt = 5'd10;
      expect_out("post_rst_r5", F_RS, 0);
      expect_out("post_rst_r10", F_RT, 0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
